// File: rtl/pipelined_execute_unit.sv
// Execute stage: single-cycle ALU ops plus an iterative shift-add multiply.
// Results land in an EX/MEM output register. Both sides use valid/ready
// handshakes. Flush kills in-flight work on a branch redirect.
module pipelined_execute_unit #(
    parameter int DATA_WIDTH  = 20,
    parameter int INSTR_WIDTH = 20,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             control,
    input  logic [DATA_WIDTH-1:0]  opA,
    input  logic [DATA_WIDTH-1:0]  opB,
    input  logic [INSTR_WIDTH-1:0] instruction,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  result,
    output logic                   ula_zero,
    output logic                   result_zero,
    output logic [INSTR_WIDTH-1:0] instruction_out
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

    state_t state, state_next;

    // Single-cycle ALU; multiply is handled by the iterative datapath.
    function automatic logic [DATA_WIDTH-1:0] alu_eval(
        input logic [2:0]            op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        logic signed [DATA_WIDTH-1:0] sa;
        logic signed [DATA_WIDTH-1:0] sb;
        logic [SHAMT_WIDTH-1:0]       shamt;
        sa       = a;
        sb       = b;
        shamt    = b[SHAMT_WIDTH-1:0];
        alu_eval = '0;
        case (op)
            OP_ADD: alu_eval = a + b;
            OP_OR:  alu_eval = a | b;
            OP_AND: alu_eval = a & b;
            OP_NOT: alu_eval = ~a;
            OP_SUB: alu_eval = a - b;
            OP_SLT: alu_eval = (sa < sb) ? DATA_WIDTH'(1) : '0;
            // Shift amounts past the word width clear the result.
            OP_SHL: alu_eval = (32'(shamt) >= 32'(DATA_WIDTH)) ? '0 : (a << shamt);
            default: alu_eval = '0;
        endcase
    endfunction

    // ---- stage p0: handshake, ALU and multiply iteration ----
    logic                   vld_p1;
    logic                   out_free;
    logic                   accept;
    logic                   is_mul;
    logic                   alu_load;
    logic                   mul_load;
    logic [DATA_WIDTH-1:0]  alu_res_p0;

    logic [DATA_WIDTH-1:0]  mcand_p0;
    logic [DATA_WIDTH-1:0]  mplier_p0;
    logic [DATA_WIDTH-1:0]  acc_p0;
    logic [CNT_W-1:0]       cnt_p0;
    logic                   mul_eq_p0;
    logic [INSTR_WIDTH-1:0] mul_instr_p0;

    assign out_free   = !vld_p1 || out_ready;
    assign in_ready   = (state == IDLE) && out_free && !flush;
    assign accept     = in_valid && in_ready;
    assign is_mul     = (control == OP_MUL);
    assign alu_load   = accept && !is_mul;
    assign mul_load   = (state == DONE) && out_free && !flush;
    assign alu_res_p0 = alu_eval(control, opA, opB);

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // FSM next-state: multiply sequencing, flush returns to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept && is_mul) state_next = MUL;
            MUL:  if (cnt_p0 == CNT_W'(DATA_WIDTH - 1)) state_next = DONE;
            DONE: if (out_free) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) state_next = IDLE;
    end

    // Multiply operand latch and one shift-add step per cycle in MUL.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcand_p0     <= '0;
            mplier_p0    <= '0;
            acc_p0       <= '0;
            cnt_p0       <= '0;
            mul_eq_p0    <= 1'b0;
            mul_instr_p0 <= '0;
        end else if (accept && is_mul) begin
            mcand_p0     <= opA;
            mplier_p0    <= opB;
            acc_p0       <= '0;
            cnt_p0       <= '0;
            mul_eq_p0    <= (opA == opB);
            mul_instr_p0 <= instruction;
        end else if ((state == MUL) && !flush) begin
            if (mplier_p0[0]) acc_p0 <= acc_p0 + mcand_p0;
            mcand_p0  <= mcand_p0 << 1;
            mplier_p0 <= mplier_p0 >> 1;
            cnt_p0    <= cnt_p0 + CNT_W'(1);
        end
    end

    // ---- stage p1: EX/MEM output register ----
    logic [DATA_WIDTH-1:0]  result_p1;
    logic                   uz_p1;
    logic                   rz_p1;
    logic [INSTR_WIDTH-1:0] instr_p1;

    // Output register: load ALU or multiply result, hold under backpressure.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_p1    <= 1'b0;
            result_p1 <= '0;
            uz_p1     <= 1'b0;
            rz_p1     <= 1'b0;
            instr_p1  <= '0;
        end else if (flush) begin
            vld_p1 <= 1'b0;
        end else if (alu_load) begin
            vld_p1    <= 1'b1;
            result_p1 <= alu_res_p0;
            uz_p1     <= (opA == opB);
            rz_p1     <= (alu_res_p0 == '0);
            instr_p1  <= instruction;
        end else if (mul_load) begin
            vld_p1    <= 1'b1;
            result_p1 <= acc_p0;
            uz_p1     <= mul_eq_p0;
            rz_p1     <= (acc_p0 == '0);
            instr_p1  <= mul_instr_p0;
        end else if (out_ready) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid       = vld_p1;
    assign result          = result_p1;
    assign ula_zero        = uz_p1;
    assign result_zero     = rz_p1;
    assign instruction_out = instr_p1;

endmodule

// File: tb/tb_pipelined_execute_unit.sv
// Directed bench for pipelined_execute_unit: ALU vector table plus
// hand-written multiply, backpressure, flush and async reset sequences.
module tb_pipelined_execute_unit;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  control;
    logic [19:0] opA;
    logic [19:0] opB;
    logic [19:0] instruction;
    logic        out_valid;
    logic        out_ready;
    logic [19:0] result;
    logic        ula_zero;
    logic        result_zero;
    logic [19:0] instruction_out;

    int checks   = 0;
    int failures = 0;

    pipelined_execute_unit #(
        .DATA_WIDTH (20),
        .INSTR_WIDTH(20),
        .SHAMT_WIDTH(5)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .control        (control),
        .opA            (opA),
        .opB            (opB),
        .instruction    (instruction),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .result         (result),
        .ula_zero       (ula_zero),
        .result_zero    (result_zero),
        .instruction_out(instruction_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]  op;
        logic [19:0] a;
        logic [19:0] b;
        logic [19:0] res;
        logic        uz;
        logic        rz;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [19:0] a, input logic [19:0] b,
                         input logic [19:0] ins);
        control     = op;
        opA         = a;
        opB         = b;
        instruction = ins;
        in_valid    = 1'b1;
    endtask

    // Waits (bounded) for out_valid; flags any cycle where in_ready was high
    // while the multiply had not yet produced its result.
    task automatic wait_out(input int budget, output int n, output logic bad_ready);
        n         = 0;
        bad_ready = 1'b0;
        do begin
            tick();
            n++;
            if (!out_valid && in_ready) bad_ready = 1'b1;
        end while (!out_valid && n < budget);
    endtask

    // Issues one multiply and checks latency, stall, result and flags.
    task automatic do_mul(input logic [19:0] a, input logic [19:0] b, input logic [19:0] ins,
                          input logic [19:0] exp_res, input logic exp_uz, input string nm);
        int   n;
        logic bad;
        issue(3'b111, a, b, ins);
        #1;
        chk({nm, "_ready_before"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk({nm, "_stall_after_accept"}, 32'(in_ready), 32'd0);
        wait_out(40, n, bad);
        chk({nm, "_latency"}, 32'(n), 32'd21);
        chk({nm, "_in_ready_low"}, 32'(bad), 32'd0);
        chk({nm, "_res"}, 32'(result), 32'(exp_res));
        chk({nm, "_uz"}, 32'(ula_zero), 32'(exp_uz));
        chk({nm, "_rz"}, 32'(result_zero), 32'(exp_res == 20'h0));
        chk({nm, "_instr"}, 32'(instruction_out), 32'(ins));
    endtask

    initial begin
        int   n;
        logic bad;
        logic seen;

        vecs[0]  = '{3'b000, 20'h00001, 20'h00001, 20'h00002, 1'b1, 1'b0};
        vecs[1]  = '{3'b000, 20'hFFFFF, 20'h00001, 20'h00000, 1'b0, 1'b1};
        vecs[2]  = '{3'b001, 20'hFFC00, 20'h00003, 20'hFFC03, 1'b0, 1'b0};
        vecs[3]  = '{3'b010, 20'h00205, 20'h0000F, 20'h00005, 1'b0, 1'b0};
        vecs[4]  = '{3'b011, 20'hFFC00, 20'h00000, 20'h003FF, 1'b0, 1'b0};
        vecs[5]  = '{3'b100, 20'h00005, 20'h00007, 20'hFFFFE, 1'b0, 1'b0};
        vecs[6]  = '{3'b101, 20'hFFFFE, 20'h00003, 20'h00001, 1'b0, 1'b0};
        vecs[7]  = '{3'b101, 20'h00003, 20'hFFFFE, 20'h00000, 1'b0, 1'b1};
        vecs[8]  = '{3'b101, 20'h80000, 20'h7FFFF, 20'h00001, 1'b0, 1'b0};
        vecs[9]  = '{3'b110, 20'h00001, 20'h00013, 20'h80000, 1'b0, 1'b0};
        vecs[10] = '{3'b110, 20'h00001, 20'h00014, 20'h00000, 1'b0, 1'b1};
        vecs[11] = '{3'b110, 20'h00003, 20'h00021, 20'h00006, 1'b0, 1'b0};
        vecs[12] = '{3'b110, 20'h00005, 20'h0001F, 20'h00000, 1'b0, 1'b1};
        vecs[13] = '{3'b100, 20'h00007, 20'h00007, 20'h00000, 1'b1, 1'b1};

        reset       = 1'b1;
        flush       = 1'b0;
        in_valid    = 1'b0;
        control     = 3'b000;
        opA         = '0;
        opB         = '0;
        instruction = '0;
        out_ready   = 1'b1;

        repeat (2) @(posedge clock);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_ula_zero", 32'(ula_zero), 32'd0);
        chk("rst_result_zero", 32'(result_zero), 32'd0);
        chk("rst_instr", 32'(instruction_out), 32'd0);
        reset = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back single-cycle ops, one per clock.
        for (int i = 0; i < 14; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, 20'(20'hA0000 + i));
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
            tick();
            chk($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("v%0d_res", i), 32'(result), 32'(vecs[i].res));
            chk($sformatf("v%0d_uz", i), 32'(ula_zero), 32'(vecs[i].uz));
            chk($sformatf("v%0d_rz", i), 32'(result_zero), 32'(vecs[i].rz));
            chk($sformatf("v%0d_instr", i), 32'(instruction_out), 32'(20'(20'hA0000 + i)));
        end
        in_valid = 1'b0;
        tick();
        chk("drain_valid_low", 32'(out_valid), 32'd0);

        // Multiplies.
        do_mul(20'd300, 20'd5, 20'h11111, 20'd1500, 1'b0, "mul300x5");
        tick();
        chk("mul_drained", 32'(out_valid), 32'd0);
        do_mul(20'hFFFFF, 20'h00002, 20'h22222, 20'hFFFFE, 1'b0, "mulwrap");
        tick();
        do_mul(20'h00003, 20'h00003, 20'h33333, 20'h00009, 1'b1, "mul3x3");
        tick();

        // Backpressure on a single-cycle op; next op waits then follows in order.
        out_ready = 1'b0;
        issue(3'b000, 20'd10, 20'd20, 20'h44444);
        #1;
        chk("bp_ready_empty", 32'(in_ready), 32'd1);
        tick();
        chk("bp_first_valid", 32'(out_valid), 32'd1);
        issue(3'b100, 20'd50, 20'd8, 20'h55555);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("bp_hold%0d_res", k), 32'(result), 32'd30);
            chk($sformatf("bp_hold%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("bp_hold%0d_instr", k), 32'(instruction_out), 32'h44444);
            chk($sformatf("bp_hold%0d_in_ready", k), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_second_res", 32'(result), 32'd42);
        chk("bp_second_instr", 32'(instruction_out), 32'h55555);
        tick();
        chk("bp_second_drained", 32'(out_valid), 32'd0);

        // Multiply result held under backpressure.
        issue(3'b111, 20'd6, 20'd7, 20'h66666);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        wait_out(40, n, bad);
        chk("bpmul_latency", 32'(n), 32'd21);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("bpmul_hold%0d_res", k), 32'(result), 32'd42);
            chk($sformatf("bpmul_hold%0d_valid", k), 32'(out_valid), 32'd1);
            chk($sformatf("bpmul_hold%0d_in_ready", k), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        chk("bpmul_drained", 32'(out_valid), 32'd0);

        // Flush five cycles into a multiply.
        issue(3'b111, 20'd100, 20'd3, 20'h77777);
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        flush = 1'b1;
        #1;
        chk("flush_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        #1;
        chk("flush_valid_low", 32'(out_valid), 32'd0);
        chk("flush_in_ready_back", 32'(in_ready), 32'd1);
        seen = 1'b0;
        repeat (25) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("flush_no_emit", 32'(seen), 32'd0);
        issue(3'b000, 20'd2, 20'd3, 20'h88888);
        tick();
        in_valid = 1'b0;
        chk("flush_next_valid", 32'(out_valid), 32'd1);
        chk("flush_next_res", 32'(result), 32'd5);
        tick();

        // Async reset mid-multiply.
        issue(3'b111, 20'd9, 20'd9, 20'h99999);
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("amul_valid", 32'(out_valid), 32'd0);
        chk("amul_in_ready", 32'(in_ready), 32'd1);
        #2;
        reset = 1'b0;
        seen = 1'b0;
        repeat (25) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        chk("amul_no_emit", 32'(seen), 32'd0);

        // Async reset while a result is held.
        out_ready = 1'b0;
        issue(3'b000, 20'd4, 20'd4, 20'h12345);
        tick();
        in_valid = 1'b0;
        chk("aout_pre_res", 32'(result), 32'd8);
        chk("aout_pre_uz", 32'(ula_zero), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("aout_valid", 32'(out_valid), 32'd0);
        chk("aout_res", 32'(result), 32'd0);
        chk("aout_uz", 32'(ula_zero), 32'd0);
        chk("aout_rz", 32'(result_zero), 32'd0);
        chk("aout_instr", 32'(instruction_out), 32'd0);
        chk("aout_in_ready", 32'(in_ready), 32'd1);
        #1;
        reset     = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("aout_still_empty", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipelined_execute_unit.md
Name: pipelined_execute_unit

Overview:
Parametrised successor to the pipeline execute-stage ALU. It adds subtract, signed set-less-than, shift-left and an iterative multiply to the existing add/or/and/not, and registers its results into an EX/MEM output register. Upstream (ID/EX) and downstream (MEM) connect through valid/ready handshakes. The multi-cycle multiply stalls the upstream stage; a synchronous flush kills work in flight on a branch redirect.

Parameters:
DATA_WIDTH, 20, operand/result width (>= 4).
INSTR_WIDTH, 20, width of the instruction word propagated alongside the result.
SHAMT_WIDTH, 5, operand-B bits used as shift amount; must satisfy 2**SHAMT_WIDTH >= DATA_WIDTH.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high; clears all state.
flush  in  1  synchronous kill of in-flight operation and output register.
in_valid  in  1  ID/EX presents an operation.
in_ready  out  1  unit can accept this cycle (combinational).
control  in  3  000 add, 001 or, 010 and, 011 not A, 100 sub A-B, 101 slt signed, 110 shl A<<B, 111 mul.
opA  in  DATA_WIDTH  operand A (register read data 1).
opB  in  DATA_WIDTH  operand B (register read data 2).
instruction  in  INSTR_WIDTH  instruction word travelling with the operation.
out_valid  out  1  EX/MEM register holds a valid result.
out_ready  in  1  MEM stage consumes the result this cycle.
result  out  DATA_WIDTH  registered result.
ula_zero  out  1  registered (opA == opB) of the operation; branch-equal flag.
result_zero  out  1  registered (result == 0).
instruction_out  out  INSTR_WIDTH  registered propagated instruction.

Behaviour:
- Reset (async, active-high): out_valid=0, result=0, ula_zero=0, result_zero=0, instruction_out=0, FSM=IDLE, multiply counter/accumulator=0. in_ready=1 after reset.
- out_free = !out_valid || out_ready. in_ready = (state==IDLE) && out_free && !flush.
- Accept occurs when in_valid && in_ready at a rising edge.
- FSM states: IDLE, MUL, DONE.
- IDLE, accept, non-mul op: result computed combinationally and loaded into the output register at that edge; out_valid=1. Latency is 1 cycle, throughput 1 op/cycle under no backpressure.
- IDLE, accept, mul: latch opA, opB, instruction and ula_zero; counter=0; go to MUL.
- MUL: one shift-add step per edge; after DATA_WIDTH steps go to DONE.
- DONE: on the first edge with out_free, load the output register, set out_valid=1 and go to IDLE. Minimum latency from accept to out_valid is DATA_WIDTH+1 cycles.
- Output register: when out_valid && out_ready with no new load, out_valid drops to 0. When out_valid && !out_ready, all outputs hold stable.
- Arithmetic, all modulo 2**DATA_WIDTH with carry/borrow discarded:
  - add: opA+opB. sub: opA-opB.
  - not: ~opA (opB ignored).
  - slt: 1 if signed(opA) < signed(opB), else 0, zero-extended.
  - shl: shift amount = opB[SHAMT_WIDTH-1:0]; any amount >= DATA_WIDTH yields 0.
  - mul: low DATA_WIDTH bits of the unsigned product.
- ula_zero = (opA == opB) for every op, sampled at accept. result_zero = (loaded result == 0).
- flush: at the edge it is sampled, FSM goes to IDLE, out_valid=0 and any mul in progress is discarded. No accept occurs in a flush cycle because in_ready=0. flush has priority over out_ready and completion.
- Reset mid-multiply: immediate return to reset values; nothing is emitted.
- in_valid while in_ready=0: not accepted. Upstream must hold its inputs stable until accepted.

Test Plan:
- Reset, then add opA=20'h00001, opB=20'h00001, out_ready=1 -> next cycle out_valid=1, result=20'h00002, ula_zero=1, result_zero=0. Then add opA=20'hFFFFF, opB=1 -> result=0, result_zero=1, ula_zero=0.
- Back-to-back ops or(20'hFFC00, 20'h00003), and(20'h00205, 20'h0000F), not(20'hFFC00), sub(5, 7), slt(20'hFFFFE, 3), shl(1, 19), shl(1, 20) -> results 20'hFFC03, 20'h00005, 20'h003FF, 20'hFFFFE, 1, 20'h80000, 0, one per cycle with in_ready held at 1.
- mul 300*5 -> in_ready=0 for the duration; out_valid rises exactly 21 cycles after accept with result=1500. mul 20'hFFFFF*2 -> 20'hFFFFE.
- Backpressure: out_ready=0 with out_valid=1 -> result held and in_ready=0; a mul completing meanwhile waits in DONE. Raising out_ready drains both results in order.
- Flush asserted 5 cycles into a mul -> out_valid stays 0, in_ready=1 the following cycle, and the next add completes normally.
- Async reset pulsed mid-mul and with out_valid=1 -> all outputs 0 immediately (no clock edge needed) and FSM=IDLE.
